// File: rtl/decode_stage.sv
// Registered, handshaked MIPS decode stage with load-use bubble insertion
// and a saturating stall counter.
module decode_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        ALU_OP,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        wa,
  output logic              Write_Reg,
  output logic              Mem_Write,
  output logic              alu_mem_s,
  output logic              rd_rt_s,
  output logic              rt_imm_s,
  output logic [DATA_W-1:0] imm_ext,
  output logic              br_eq,
  output logic              br_ne,
  output logic              jump,
  output logic [25:0]       jaddr,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [2:0]        alu_op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        wa;
    logic              write_reg;
    logic              mem_write;
    logic              alu_mem_s;
    logic              rd_rt_s;
    logic              rt_imm_s;
    logic [DATA_W-1:0] imm_ext;
    logic              br_eq;
    logic              br_ne;
    logic              jump;
    logic [25:0]       jaddr;
    logic              illegal;
  } dec_t;

  dec_t             dec_d, dec_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [5:0]       opcode, funct;
  logic             reads_rs, reads_rt, hazard, accept;
  logic [DATA_W-1:0] imm_sext, imm_zext;

  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign imm_sext = DATA_W'(signed'(inst[15:0]));
  assign imm_zext = DATA_W'(inst[15:0]);

  always_comb begin
    dec_d         = '0;
    dec_d.rs      = inst[25:21];
    dec_d.rt      = inst[20:16];
    dec_d.rd      = inst[15:11];
    dec_d.jaddr   = inst[25:0];
    dec_d.imm_ext = imm_sext;
    unique case (opcode)
      6'b000000: begin
        dec_d.write_reg = 1'b1;
        unique case (funct)
          6'b100000: dec_d.alu_op = 3'b100;
          6'b100010: dec_d.alu_op = 3'b101;
          6'b100100: dec_d.alu_op = 3'b000;
          6'b100101: dec_d.alu_op = 3'b001;
          6'b100110: dec_d.alu_op = 3'b010;
          6'b100111: dec_d.alu_op = 3'b011;
          6'b101011: dec_d.alu_op = 3'b110;
          6'b000100: dec_d.alu_op = 3'b111;
          default: begin
            dec_d.write_reg = 1'b0;
            dec_d.illegal   = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001100, 6'b001110, 6'b001011: begin
        dec_d.write_reg = 1'b1;
        dec_d.rd_rt_s   = 1'b1;
        dec_d.rt_imm_s  = 1'b1;
        unique case (opcode)
          6'b001000: dec_d.alu_op = 3'b100;
          6'b001100: begin
            dec_d.alu_op  = 3'b000;
            dec_d.imm_ext = imm_zext;
          end
          6'b001110: begin
            dec_d.alu_op  = 3'b010;
            dec_d.imm_ext = imm_zext;
          end
          default: dec_d.alu_op = 3'b110;
        endcase
      end
      6'b100011: begin
        dec_d.write_reg = 1'b1;
        dec_d.alu_mem_s = 1'b1;
        dec_d.rd_rt_s   = 1'b1;
        dec_d.rt_imm_s  = 1'b1;
        dec_d.alu_op    = 3'b100;
      end
      6'b101011: begin
        dec_d.mem_write = 1'b1;
        dec_d.rt_imm_s  = 1'b1;
        dec_d.alu_op    = 3'b100;
      end
      6'b000100: begin
        dec_d.br_eq  = 1'b1;
        dec_d.alu_op = 3'b101;
      end
      6'b000101: begin
        dec_d.br_ne  = 1'b1;
        dec_d.alu_op = 3'b101;
      end
      6'b000010: dec_d.jump = 1'b1;
      default:   dec_d.illegal = 1'b1;
    endcase
    dec_d.wa = dec_d.rd_rt_s ? dec_d.rt : dec_d.rd;
  end

  // Only lw sets alu_mem_s, so it identifies a held load.
  assign reads_rs = (opcode != 6'b000010);
  assign reads_rt = (opcode == 6'b000000) || (opcode == 6'b101011) ||
                    (opcode == 6'b000100) || (opcode == 6'b000101);
  assign hazard   = HAZARD_EN && out_valid_q && dec_q.alu_mem_s && (dec_q.rt != 5'd0) &&
                    ((reads_rs && (inst[25:21] == dec_q.rt)) ||
                     (reads_rt && (inst[20:16] == dec_q.rt)));
  assign in_ready = !out_valid_q || (out_ready && !hazard);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (accept) begin
        dec_q <= dec_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign ALU_OP    = dec_q.alu_op;
  assign rs        = dec_q.rs;
  assign rt        = dec_q.rt;
  assign rd        = dec_q.rd;
  assign wa        = dec_q.wa;
  assign Write_Reg = dec_q.write_reg;
  assign Mem_Write = dec_q.mem_write;
  assign alu_mem_s = dec_q.alu_mem_s;
  assign rd_rt_s   = dec_q.rd_rt_s;
  assign rt_imm_s  = dec_q.rt_imm_s;
  assign imm_ext   = dec_q.imm_ext;
  assign br_eq     = dec_q.br_eq;
  assign br_ne     = dec_q.br_ne;
  assign jump      = dec_q.jump;
  assign jaddr     = dec_q.jaddr;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one hazard-enabled instance for the main
// sequence and one hazard-disabled instance for the bypass comparison.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_valid2;
  logic [31:0] inst, inst2;
  int          total = 0;
  int          bad   = 0;

  logic        in_ready, out_valid, Write_Reg, Mem_Write, alu_mem_s, rd_rt_s, rt_imm_s;
  logic        br_eq, br_ne, jump, illegal;
  logic [2:0]  ALU_OP;
  logic [4:0]  rs, rt, rd, wa;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2, wr2, mw2, ams2, rrs2, ris2, beq2, bne2, j2, ill2;
  logic [2:0]  alu2;
  logic [4:0]  rs2, rt2, rd2, wa2;
  logic [31:0] imm2;
  logic [25:0] jaddr2;
  logic [15:0] stall2;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(32), .HAZARD_EN(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_OP(ALU_OP), .rs(rs), .rt(rt),
    .rd(rd), .wa(wa), .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .alu_mem_s(alu_mem_s),
    .rd_rt_s(rd_rt_s), .rt_imm_s(rt_imm_s), .imm_ext(imm_ext), .br_eq(br_eq),
    .br_ne(br_ne), .jump(jump), .jaddr(jaddr), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  decode_stage #(.DATA_W(32), .HAZARD_EN(1'b0), .CNT_W(16)) u_nohaz (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .inst(inst2),
    .out_valid(out_valid2), .out_ready(1'b1), .ALU_OP(alu2), .rs(rs2), .rt(rt2),
    .rd(rd2), .wa(wa2), .Write_Reg(wr2), .Mem_Write(mw2), .alu_mem_s(ams2),
    .rd_rt_s(rrs2), .rt_imm_s(ris2), .imm_ext(imm2), .br_eq(beq2),
    .br_ne(bne2), .jump(j2), .jaddr(jaddr2), .illegal(ill2), .stall_cnt(stall2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inst = '0;
    in_valid2 = 1'b0; inst2 = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_op", 32'(ALU_OP), 32'd0);
    check("rst_imm_ext", imm_ext, 32'd0);
    check("rst_jaddr", 32'(jaddr), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    // add $3,$1,$2
    inst = 32'h0022_1820; in_valid = 1'b1;
    tick();
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_alu", 32'(ALU_OP), 32'd4);
    check("add_wa", 32'(wa), 32'd3);
    check("add_wr", 32'(Write_Reg), 32'd1);
    check("add_ill", 32'(illegal), 32'd0);
    check("add_rs", 32'(rs), 32'd1);

    // addi $5,$0,-1 then andi $5,$0,0xffff back-to-back
    inst = 32'h2005_FFFF;
    tick();
    check("addi_imm", imm_ext, 32'hFFFF_FFFF);
    check("addi_wa", 32'(wa), 32'd5);
    check("addi_rtimm", 32'(rt_imm_s), 32'd1);
    check("addi_alu", 32'(ALU_OP), 32'd4);
    inst = 32'h3005_FFFF;
    tick();
    check("andi_imm", imm_ext, 32'h0000_FFFF);
    check("andi_wa", 32'(wa), 32'd5);
    check("andi_rtimm", 32'(rt_imm_s), 32'd1);
    check("andi_alu", 32'(ALU_OP), 32'd0);

    // lw $4,0($1) then add $6,$4,$2: one bubble
    inst = 32'h8C24_0000;
    tick();
    check("lw_memsel", 32'(alu_mem_s), 32'd1);
    check("lw_wa", 32'(wa), 32'd4);
    inst = 32'h0082_3020;
    #1;
    check("lwuse_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("bubble_valid", 32'(out_valid), 32'd0);
    check("bubble_stall", 32'(stall_cnt), 32'd1);
    check("bubble_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("dep_valid", 32'(out_valid), 32'd1);
    check("dep_wa", 32'(wa), 32'd6);
    check("dep_stall", 32'(stall_cnt), 32'd1);

    // lw $4 then sw $4,0($1): hazard through the rt read
    inst = 32'h8C24_0000;
    tick();
    inst = 32'hAC24_0000;
    #1;
    check("lwsw_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("lwsw_bubble", 32'(out_valid), 32'd0);
    check("lwsw_stall", 32'(stall_cnt), 32'd2);
    tick();
    check("lwsw_memwr", 32'(Mem_Write), 32'd1);
    check("lwsw_rt", 32'(rt), 32'd4);

    // lw $0 then add $6,$0,$2: rt=0 is exempt
    inst = 32'h8C20_0000;
    tick();
    inst = 32'h0002_3020;
    #1;
    check("lw0_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("lw0_valid", 32'(out_valid), 32'd1);
    check("lw0_wa", 32'(wa), 32'd6);
    check("lw0_stall", 32'(stall_cnt), 32'd2);

    // sw $2,8($1) held for 3 cycles, xori $7,$1,0xf0 waiting
    inst = 32'hAC22_0008;
    tick();
    out_ready = 1'b0;
    inst = 32'h3827_00F0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_memwr", 32'(Mem_Write), 32'd1);
      check("hold_imm", imm_ext, 32'd8);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("xori_imm", imm_ext, 32'h0000_00F0);
    check("xori_alu", 32'(ALU_OP), 32'd2);
    check("xori_wa", 32'(wa), 32'd7);
    check("xori_memwr", 32'(Mem_Write), 32'd0);

    // j 0x123, beq $1,$2,4
    inst = 32'h0800_0123;
    tick();
    check("j_jump", 32'(jump), 32'd1);
    check("j_jaddr", 32'(jaddr), 32'h123);
    check("j_wr", 32'(Write_Reg), 32'd0);
    inst = 32'h1022_0004;
    tick();
    check("beq_br", 32'(br_eq), 32'd1);
    check("beq_alu", 32'(ALU_OP), 32'd5);
    check("beq_jump", 32'(jump), 32'd0);
    check("beq_imm", imm_ext, 32'd4);

    // illegal opcode, then illegal R-type funct
    inst = 32'hFC00_0000;
    tick();
    check("ill_op", 32'(illegal), 32'd1);
    check("ill_op_ctl", {28'd0, Write_Reg, Mem_Write, alu_mem_s, jump}, 32'd0);
    check("ill_op_br", {30'd0, br_eq, br_ne}, 32'd0);
    check("ill_op_valid", 32'(out_valid), 32'd1);
    inst = 32'h0022_1800;
    tick();
    check("ill_fn", 32'(illegal), 32'd1);
    check("ill_fn_wr", 32'(Write_Reg), 32'd0);
    check("ill_fn_rd", 32'(rd), 32'd3);

    // reset while holding, with a competing handshake
    out_ready = 1'b0;
    rst = 1'b1;
    inst = 32'h0022_1820;
    tick();
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_ill", 32'(illegal), 32'd0);
    check("rst_hold_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // hazard disabled: lw $4 then add $6,$4,$2 with no bubble
    inst2 = 32'h8C24_0000; in_valid2 = 1'b1;
    tick();
    inst2 = 32'h0082_3020;
    #1;
    check("nohaz_in_ready", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    check("nohaz_valid", 32'(out_valid2), 32'd1);
    check("nohaz_wa", 32'(wa2), 32'd6);
    check("nohaz_stall", 32'(stall2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
